mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from mem_en high to mem_rdata valid; legal range 1..15.
REQ-002 Parameter XLEN, default 32: address and data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request; held high with if_addr stable until if_ack.
REQ-006 if_addr  input  XLEN  fetch address.
REQ-007 if_ack  output  1  one-cycle pulse; fetch complete, if_rdata valid this cycle.
REQ-008 if_rdata  output  XLEN  fetched word, registered.
REQ-009 d_req, d_we  input  1 each  data request, write enable; held stable with d_addr/d_wdata until d_ack.
REQ-010 d_addr, d_wdata  input  XLEN each  data address, store data.
REQ-011 d_ack  output  1  one-cycle pulse; data access complete, d_rdata valid this cycle for loads.
REQ-012 d_rdata  output  XLEN  load data, registered.
REQ-013 mem_en, mem_we  output  1 each  single-port memory strobe, write enable.
REQ-014 mem_addr, mem_wdata  output  XLEN each  memory address, write data.
REQ-015 mem_rdata  input  XLEN  memory read data, valid MEM_LAT cycles after mem_en.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, WAIT, DONE; one access in flight at a time.
REQ-018 IDLE: no req -> stay; any req -> latch winner's addr/we/wdata and grant owner, go ACCESS.
REQ-019 Arbitration round-robin via last_grant register: single requester always wins; both pending -> requester not equal to last_grant wins.
REQ-020 ACCESS: mem_en=1 for exactly one cycle, mem_addr/mem_we/mem_wdata from latched regs; fetch grants always drive mem_we=0.
REQ-021 ACCESS -> WAIT when MEM_LAT>1, loading wait counter with MEM_LAT-1; ACCESS -> DONE when MEM_LAT=1.
REQ-022 WAIT: decrement counter each cycle; counter reaching 1 -> DONE next edge.
REQ-023 DONE: capture mem_rdata into owner's rdata register; pulse owner's ack one cycle; update last_grant; go IDLE.
REQ-024 Latency: req sampled at edge N -> ack high in cycle N+MEM_LAT+2; identical for loads, stores, fetches.
REQ-025 Writes: d_rdata loaded with mem_rdata in DONE as well, content don't-care to requester.
REQ-026 Requesters drop req at the edge where ack is seen; arbiter samples req only in IDLE, so no double grant.
REQ-027 Non-owner rdata registers and acks unchanged during another owner's access; a request arriving mid-access waits in IDLE arbitration.
REQ-028 mem_en, mem_we low outside ACCESS; mem_addr/mem_wdata hold latched values.

Reset
REQ-029 rst high: state=IDLE, mem_en=0, mem_we=0, if_ack=0, d_ack=0, busy=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, counter=0, last_grant=DATA.
REQ-030 rst asserted mid-access discards the transaction: no ack issued, mem_en drops immediately.
REQ-031 First cycle after rst release with both reqs high grants fetch.

Structure
REQ-032 State encoding, owner encoding (FETCH/DATA) and MEM_LAT default live in shared package riscv_pkg, reused by uc.
REQ-033 Two-input round-robin selector is one sub-module, arb_rr2 (inputs: two reqs, last_grant; output: winner); rest stays in mem_arbiter.

Verification (MEM_LAT=2 unless noted)
REQ-034 if_req=1, if_addr=0x100, mem_rdata=0x00A00093 at N+3 -> mem_en in cycle N+1 only, if_ack and if_rdata=0x00A00093 in cycle N+4.
REQ-035 d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> one mem_en with mem_we=1, mem_wdata=0xDEADBEEF, d_ack at N+4, if_ack stays 0.
REQ-036 Both reqs held continuously after reset -> grants alternate fetch, data, fetch, data; one ack per 5 cycles.
REQ-037 rst pulsed during WAIT -> no ack, busy=0 and mem_en=0 within the reset cycle; next request completes normally.
REQ-038 MEM_LAT=1, single fetch -> no WAIT state, if_ack at N+3.
REQ-039 d_req raised during a fetch's WAIT -> fetch acks first, data granted at next IDLE, d_ack 4 cycles after it.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the memory arbiter and core blocks
package riscv_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Owner of the access currently in flight
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    // Default memory read latency in cycles from mem_en to mem_rdata
    localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-input round-robin winner select
module arb_rr2
    import riscv_pkg::*;
(
    input  logic   req_fetch,
    input  logic   req_data,
    input  owner_t last_grant,
    output owner_t winner
);

    // A lone requester wins; on a tie the side that did not go last wins
    always_comb begin
        winner = FETCH;
        if (req_data && (!req_fetch || last_grant == FETCH)) begin
            winner = DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-port fixed-latency memory
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    state_t     state_q;
    state_t     state_d;
    owner_t     owner_q;
    owner_t     last_grant_q;
    owner_t     winner;
    logic       we_q;
    logic [3:0] cnt_q;
    logic       grant;

    arb_rr2 u_arb (
        .req_fetch  (if_req),
        .req_data   (d_req),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    // The ack cycle is a turnaround: the finishing requester is still
    // withdrawing its request, so no new grant is taken while an ack is out.
    assign grant  = (state_q == IDLE) && (if_req || d_req) && !if_ack && !d_ack;
    assign mem_en = (state_q == ACCESS);
    assign mem_we = (state_q == ACCESS) && we_q;
    assign busy   = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = (MEM_LAT > 1) ? WAIT : DONE;
            WAIT:    if (cnt_q == 4'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, latency counter, read-data capture and ack pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= FETCH;
            last_grant_q <= DATA;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q  <= winner;
                        we_q     <= (winner == DATA) && d_we;
                        mem_addr <= (winner == DATA) ? d_addr : if_addr;
                        if (winner == DATA) begin
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (MEM_LAT > 1) begin
                        cnt_q <= 4'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: begin
                    last_grant_q <= owner_q;
                    if (owner_q == FETCH) begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end else begin
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_req1, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        ovr_en;
    logic [31:0] ovr_val, mem_q;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    // Memory model: returns address xor 0x5A5A0000, latched when the main DUT strobes
    always @(posedge clk) begin
        if (mem_en) mem_q <= mem_addr ^ 32'h5A5A_0000;
    end
    assign mem_rdata = ovr_en ? ovr_val : mem_q;

    mem_arbiter #(.MEM_LAT(2), .XLEN(32)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1), .XLEN(32)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; if_req = 0; if_req1 = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; ovr_en = 1'b1; ovr_val = 0;
        tick; tick;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        // Single fetch
        ovr_val = 32'h00A0_0093; if_addr = 32'h100; if_req = 1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            check($sformatf("fetch_mem_en_c%0d", k), mem_en, k == 1);
            check($sformatf("fetch_if_ack_c%0d", k), if_ack, k == 4);
            check($sformatf("fetch_d_ack_c%0d", k), d_ack, 0);
            if (k == 1) check("fetch_mem_addr", mem_addr, 32'h100);
            if (k == 1) check("fetch_mem_we", mem_we, 0);
            if (k == 2) check("fetch_busy", busy, 1);
            if (k == 4) begin
                check("fetch_if_rdata", if_rdata, 32'h00A0_0093);
                check("fetch_busy_ack", busy, 0);
                if_req = 0;
            end
        end

        // Single store
        d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_req = 1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            check($sformatf("store_mem_en_c%0d", k), mem_en, k == 1);
            check($sformatf("store_mem_we_c%0d", k), mem_we, k == 1);
            check($sformatf("store_d_ack_c%0d", k), d_ack, k == 4);
            check($sformatf("store_if_ack_c%0d", k), if_ack, 0);
            if (k == 1) check("store_mem_addr", mem_addr, 32'h200);
            if (k == 1) check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            if (k == 3) check("store_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
            if (k == 4) begin d_req = 0; d_we = 0; end
        end

        // Data request arriving during a fetch's WAIT
        ovr_en = 0; if_addr = 32'h500; if_req = 1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            check($sformatf("mid_mem_en_c%0d", k), mem_en, (k == 1) || (k == 6));
            check($sformatf("mid_if_ack_c%0d", k), if_ack, k == 4);
            check($sformatf("mid_d_ack_c%0d", k), d_ack, k == 9);
            if (k == 2) begin d_addr = 32'h600; d_we = 0; d_req = 1; end
            if (k == 4) begin
                check("mid_if_rdata", if_rdata, 32'h5A5A_0500);
                if_req = 0;
            end
            if (k == 6) check("mid_mem_addr", mem_addr, 32'h600);
            if (k == 9) begin
                check("mid_d_rdata", d_rdata, 32'h5A5A_0600);
                d_req = 0;
            end
            if (k == 10) check("mid_busy_end", busy, 0);
        end

        // Reset pulsed during WAIT, then a clean fetch
        if_addr = 32'h300; if_req = 1;
        tick; tick;
        check("rstw_busy_wait", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_mem_en", mem_en, 0);
        check("rstw_if_ack", if_ack, 0);
        if_req = 0;
        tick; tick;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            check($sformatf("rstw_no_ack_c%0d", k), if_ack, 0);
            check($sformatf("rstw_idle_c%0d", k), busy, 0);
        end
        ovr_en = 1; ovr_val = 32'h1111_1111; if_addr = 32'h104; if_req = 1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            check($sformatf("rstw_mem_en_c%0d", k), mem_en, k == 1);
            check($sformatf("rstw_if_ack2_c%0d", k), if_ack, k == 4);
            if (k == 4) begin
                check("rstw_if_rdata", if_rdata, 32'h1111_1111);
                if_req = 0;
            end
        end

        // Both requesters held from reset release: fetch first, then alternate
        rst = 1'b1; ovr_en = 0;
        if_addr = 32'h400; d_addr = 32'h800; d_we = 0; if_req = 1; d_req = 1;
        tick;
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            check($sformatf("rr_mem_en_c%0d", k), mem_en, (k % 5) == 1);
            check($sformatf("rr_if_ack_c%0d", k), if_ack, (k % 10) == 4);
            check($sformatf("rr_d_ack_c%0d", k), d_ack, (k % 10) == 9);
            if ((k % 5) == 1)
                check($sformatf("rr_mem_addr_c%0d", k), mem_addr,
                      ((k % 10) == 1) ? 32'h400 : 32'h800);
            if ((k % 10) == 4) check($sformatf("rr_if_rdata_c%0d", k), if_rdata, 32'h5A5A_0400);
            if ((k % 10) == 9) check($sformatf("rr_d_rdata_c%0d", k), d_rdata, 32'h5A5A_0800);
            if (k == 19) begin if_req = 0; d_req = 0; end
        end
        tick;
        check("rr_busy_end", busy, 0);
        check("rr_mem_en_end", mem_en, 0);

        // MEM_LAT=1 instance: no WAIT, ack at N+3
        ovr_en = 1; ovr_val = 32'h0BAD_F00D; if_addr = 32'h700; if_req1 = 1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            check($sformatf("lat1_mem_en_c%0d", k), mem_en1, k == 1);
            check($sformatf("lat1_if_ack_c%0d", k), if_ack1, k == 3);
            check($sformatf("lat1_busy_c%0d", k), busy1, k <= 2);
            if (k == 3) begin
                check("lat1_if_rdata", if_rdata1, 32'h0BAD_F00D);
                if_req1 = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
